// File: rtl/serdes_pkg.sv
// Shared types and helpers for the serializer / capture-latch pair.
package serdes_pkg;

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} ser_state_t;

   // Width of a word index within a frame; never narrower than one bit.
   function automatic int idx_w(input int stage);
      int w;
      w = $clog2(stage);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/ser_frame_ctrl.sv
// Frame sequencer for the serializer: IDLE/SHIFT state, word index,
// ready generation and registered start/last strobes.
module ser_frame_ctrl
   import serdes_pkg::*;
#(
   parameter int STAGE = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load,
   input  logic                      hold,
   output logic                      ready,
   output logic                      accept,   // a frame is taken at this edge
   output logic                      advance,  // move to the next word at this edge
   output logic                      finish,   // frame ends with nothing queued behind it
   output logic [idx_w(STAGE)-1:0]   nxt_idx,
   output logic                      busy,
   output logic                      start_out,
   output logic                      last_out
);

   localparam int             IW       = idx_w(STAGE);
   localparam logic [IW-1:0]  LAST     = IW'(STAGE - 1);
   localparam bit             ONE_WORD = (STAGE == 1);

   ser_state_t    state;
   logic [IW-1:0] idx;
   logic          at_last;
   logic          shifting;

   // Handshake and step decisions derived from the current state, index and hold.
   always_comb begin
      shifting = (state == SHIFT);
      at_last  = (idx == LAST);
      nxt_idx  = idx + IW'(1);
      ready    = !shifting || (at_last && !hold);
      accept   = load && ready;
      advance  = shifting && !hold && !at_last;
      finish   = shifting && !hold && at_last && !load;
   end

   // Frame sequencing: state, word index and the registered frame strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         start_out <= 1'b0;
         last_out  <= 1'b0;
      end else if (accept) begin
         state     <= SHIFT;
         idx       <= '0;
         start_out <= 1'b1;
         last_out  <= ONE_WORD;
      end else if (advance) begin
         idx       <= nxt_idx;
         start_out <= 1'b0;
         last_out  <= (nxt_idx == LAST);
      end else if (finish) begin
         state     <= IDLE;
         idx       <= '0;
         start_out <= 1'b0;
         last_out  <= 1'b0;
      end
   end

   assign busy = (state == SHIFT);

endmodule

// File: rtl/data_serializer.sv
// Parallel-to-serial frame emitter: takes STAGE words on an accepted load and
// plays them out one per clock, word 0 first, with start/last framing.
module data_serializer
   import serdes_pkg::*;
#(
   parameter int STAGE  = 8,
   parameter int DWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DWIDTH-1:0] data_par [0:STAGE-1],
   input  logic              hold,
   output logic              ready,
   output logic [DWIDTH-1:0] data_out,
   output logic              valid,
   output logic              start_out,
   output logic              last_out,
   output logic              busy
);

   localparam int IW = idx_w(STAGE);

   logic [DWIDTH-1:0] frame_buf [0:STAGE-1];
   logic              accept;
   logic              advance;
   logic              finish;
   logic [IW-1:0]     nxt_idx;

   ser_frame_ctrl #(.STAGE(STAGE)) u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .hold      (hold),
      .ready     (ready),
      .accept    (accept),
      .advance   (advance),
      .finish    (finish),
      .nxt_idx   (nxt_idx),
      .busy      (busy),
      .start_out (start_out),
      .last_out  (last_out)
   );

   // valid and busy are the same registered state bit.
   assign valid = busy;

   // Frame buffer: data_par is sampled only on the accepting edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGE; i++) frame_buf[i] <= '0;
      end else if (accept) begin
         frame_buf <= data_par;
      end
   end

   // Output word register: word 0 comes straight from data_par so it shows
   // in the cycle right after acceptance; later words come from the buffer.
   always_ff @(posedge clk) begin
      if (rst || finish) begin
         data_out <= '0;
      end else if (accept) begin
         data_out <= data_par[0];
      end else if (advance) begin
         data_out <= frame_buf[nxt_idx];
      end
   end

endmodule
